// File: rtl/imm_pkg.sv
// imm_pkg
// Shared definitions for the pipelined immediate generator:
//   - format codes carried on out_op
//   - RISC-V base opcodes that carry an immediate
//   - the width-independent part of a buffered entry (format + illegal flag)
//   - decode_fmt(): opcode/funct3 to format code
package imm_pkg;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_Z    = 3'd5;
  localparam logic [2:0] IMM_SH   = 3'd6;
  localparam logic [2:0] IMM_RSVD = 3'd7;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Width-independent part of an entry; the top level wraps it together
  // with the XLEN-wide immediate and the TAG_W-wide tag.
  typedef struct packed {
    logic [2:0] op;
    logic       illegal;
  } imm_meta_t;

  // Opcode/funct3 to format code. Any opcode not listed (including words
  // whose low two bits are not 11) resolves to IMM_RSVD, which the
  // extractor turns into an illegal, zero immediate. The W-form shifts
  // exist only on RV64.
  function automatic logic [2:0] decode_fmt(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic       rv64);
    logic [2:0] fmt;
    fmt = IMM_RSVD;
    case (opcode)
      OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_OP_IMM:         fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
      OPC_OP_IMM_32: begin
        if (rv64) begin
          fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
        end
      end
      OPC_STORE:          fmt = IMM_S;
      OPC_BRANCH:         fmt = IMM_B;
      OPC_LUI, OPC_AUIPC: fmt = IMM_U;
      OPC_JAL:            fmt = IMM_J;
      OPC_SYSTEM:         fmt = funct3[2] ? IMM_Z : IMM_I;
      default:            fmt = IMM_RSVD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// imm_extract
// Purely combinational immediate extraction for one instruction word.
// Ports:
//   inst    [31:0]      instruction word
//   op      [2:0]       format code (imm_pkg IMM_*)
//   imm     [XLEN-1:0]  extended immediate (0 for the reserved code)
//   illegal             high for the reserved format code
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^inst[6:0];

  // Every format is first assembled as a 32-bit sign-extended value; Z and
  // SH are zero-extended and therefore have bit 31 clear, so the later
  // widening to XLEN can uniformly replicate bit 31.
  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (op)
      IMM_I:  raw = {{20{inst[31]}}, inst[31:20]};
      IMM_S:  raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:  raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:  raw = {inst[31:12], 12'h000};
      IMM_J:  raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:  raw = {27'd0, inst[19:15]};
      IMM_SH: raw = (XLEN == 64) ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
      default: begin
        raw     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Widening is split by generate so the RV32 build never sees a
  // zero-width replication.
  if (XLEN == 64) begin : g_rv64
    assign imm = {{32{raw[31]}}, raw};
  end else begin : g_rv32
    assign imm = raw;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Registered, handshaked immediate generator placed between IF/ID and ID/EX.
// One entry per cycle, 1-cycle latency, two-entry skid storage (main + skid)
// so downstream backpressure never drops an entry.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              drop all stored entries and any same-cycle input
//   in_valid/in_ready  upstream handshake
//   in_inst, in_op     instruction word; in_op used only when AUTO_DECODE=0
//   in_tag             sideband tag (normally the PC)
//   out_valid/out_ready downstream handshake
//   out_imm, out_op    extended immediate and resolved format code
//   out_tag            tag of the presented entry
//   out_illegal        no immediate format for this instruction
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_op,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_meta_t        meta;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [2:0]      selOp;
  logic [31:0]     extInst;
  logic [XLEN-1:0] extImm;
  logic            extIllegal;
  logic            unused_inop;
  entry_t          newEntry;
  entry_t          mainQ;
  entry_t          skidQ;
  logic            mainValid;
  logic            skidValid;
  logic            inFire;
  logic            drainOrEmpty;

  assign unused_inop = ^in_op;

  // Resolve the format code. The RV64 W-form shifts only have a 5-bit
  // shamt, so bit 25 is cleared before extraction to make the 64-bit
  // extractor produce a 5-bit value for them.
  always_comb begin
    selOp   = in_op;
    extInst = in_inst;
    if (AUTO_DECODE) begin
      selOp = decode_fmt(in_inst[6:0], in_inst[14:12], XLEN == 64);
      if (in_inst[6:0] == OPC_OP_IMM_32) begin
        extInst[25] = 1'b0;
      end
    end
  end

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst   (extInst),
    .op     (selOp),
    .imm    (extImm),
    .illegal(extIllegal)
  );

  // An illegal entry already carries op=7 and imm=0 from the extractor.
  always_comb begin
    newEntry              = '0;
    newEntry.imm          = extImm;
    newEntry.meta.op      = selOp;
    newEntry.meta.illegal = extIllegal;
    newEntry.tag          = in_tag;
  end

  // in_ready is simply "skid is free", and is held low during reset.
  assign in_ready     = !skidValid && !rst;
  assign inFire       = in_valid && in_ready;
  assign drainOrEmpty = !mainValid || out_ready;

  // Two-entry storage. When main can move (empty or being drained) it is
  // refilled from skid first to keep FIFO order; an input can only arrive
  // in that case if skid is empty, because in_ready is low otherwise. When
  // main is stalled, an accepted input parks in skid. Flush wins over any
  // same-cycle transfer, and reset additionally clears the payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainQ     <= '0;
      skidQ     <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (drainOrEmpty) begin
      if (skidValid) begin
        mainQ     <= skidQ;
        mainValid <= 1'b1;
        skidValid <= 1'b0;
      end else begin
        mainValid <= inFire;
        if (inFire) begin
          mainQ <= newEntry;
        end
      end
    end else if (inFire) begin
      skidQ     <= newEntry;
      skidValid <= 1'b1;
    end
  end

  assign out_valid   = mainValid;
  assign out_imm     = mainQ.imm;
  assign out_op      = mainQ.meta.op;
  assign out_illegal = mainQ.meta.illegal;
  assign out_tag     = mainQ.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe. Three instances share all inputs:
//   d32 : XLEN=32, auto decode
//   d64 : XLEN=64, auto decode
//   dm  : XLEN=32, format taken from in_op
// Inputs are driven at the falling edge; outputs are compared at the
// falling edge, half a cycle after the rising edge that updated them.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_op;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tag32;
  logic [2:0]  op32;

  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  op64;

  logic        rdym, vldm, illm;
  logic [31:0] immm, tagm;
  logic [2:0]  opm;

  int compared;
  int mismatched;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  inop;
    logic [63:0] e32Imm;
    logic [2:0]  e32Op;
    logic [63:0] e64Imm;
    logic [2:0]  e64Op;
    logic [63:0] emImm;
    logic [2:0]  emOp;
  } vec_t;

  vec_t vecs[10];

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b1)) d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_op(op32), .out_tag(tag32),
    .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .AUTO_DECODE(1'b1)) d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_op(op64), .out_tag(tag64),
    .out_illegal(ill64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b0)) dm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdym),
    .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag), .out_valid(vldm),
    .out_ready(out_ready), .out_imm(immm), .out_op(opm), .out_tag(tagm),
    .out_illegal(illm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives one upstream offer (or idles the input when valid=0).
  task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                               input logic [2:0] op, input logic [31:0] tag);
    in_valid = valid;
    in_inst  = inst;
    in_op    = op;
    in_tag   = tag;
  endtask

  // Hand-computed expectations: inst, in_op, RV32 auto, RV64 auto, manual.
  initial begin
    vecs[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 64'hFFFFFFFF, 3'd0};
    vecs[1] = '{32'h123450B7, 3'd7, 64'h12345000, 3'd3, 64'h0000000012345000, 3'd3, 64'h0, 3'd7};
    vecs[2] = '{32'hFE000EE3, 3'd1, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 64'hFFFFFFFD, 3'd1};
    vecs[3] = '{32'h001000EF, 3'd4, 64'h00000800, 3'd4, 64'h0000000000000800, 3'd4, 64'h00000800, 3'd4};
    vecs[4] = '{32'h000FD073, 3'd5, 64'h0000001F, 3'd5, 64'h000000000000001F, 3'd5, 64'h0000001F, 3'd5};
    vecs[5] = '{32'h0000007F, 3'd0, 64'h0, 3'd7, 64'h0, 3'd7, 64'h0, 3'd0};
    vecs[6] = '{32'h03F09093, 3'd6, 64'h0000001F, 3'd6, 64'h000000000000003F, 3'd6, 64'h0000001F, 3'd6};
    vecs[7] = '{32'h800000B7, 3'd3, 64'h80000000, 3'd3, 64'hFFFFFFFF80000000, 3'd3, 64'h80000000, 3'd3};
    vecs[8] = '{32'h03F0909B, 3'd6, 64'h0, 3'd7, 64'h000000000000001F, 3'd6, 64'h0000001F, 3'd6};
    vecs[9] = '{32'hFE112E23, 3'd1, 64'hFFFFFFFC, 3'd1, 64'hFFFFFFFFFFFFFFFC, 3'd1, 64'hFFFFFFFC, 3'd1};
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'd0, 32'h0);

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready_low", {63'd0, rdy32}, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", {63'd0, vld32}, 64'd0);
    checkOutput("rst_out_imm", {32'd0, imm32}, 64'd0);
    checkOutput("rst_out_op", {61'd0, op32}, 64'd0);
    checkOutput("rst_out_tag", {32'd0, tag32}, 64'd0);
    checkOutput("rst_out_illegal", {63'd0, ill32}, 64'd0);
    checkOutput("rst_in_ready_high", {63'd0, rdy32}, 64'd1);

    // Back-to-back stream with out_ready held high: one result per cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].inst, vecs[i].inop, 32'h1000 + 32'(i * 4));
      checkOutput($sformatf("v%0d_in_ready", i), {63'd0, rdy32}, 64'd1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid32", i), {63'd0, vld32}, 64'd1);
      checkOutput($sformatf("v%0d_imm32", i), {32'd0, imm32}, vecs[i].e32Imm);
      checkOutput($sformatf("v%0d_op32", i), {61'd0, op32}, {61'd0, vecs[i].e32Op});
      checkOutput($sformatf("v%0d_ill32", i), {63'd0, ill32}, {63'd0, vecs[i].e32Op == 3'd7});
      checkOutput($sformatf("v%0d_tag32", i), {32'd0, tag32}, 64'h1000 + 64'(i * 4));
      checkOutput($sformatf("v%0d_imm64", i), imm64, vecs[i].e64Imm);
      checkOutput($sformatf("v%0d_op64", i), {61'd0, op64}, {61'd0, vecs[i].e64Op});
      checkOutput($sformatf("v%0d_ill64", i), {63'd0, ill64}, {63'd0, vecs[i].e64Op == 3'd7});
      checkOutput($sformatf("v%0d_immm", i), {32'd0, immm}, vecs[i].emImm);
      checkOutput($sformatf("v%0d_opm", i), {61'd0, opm}, {61'd0, vecs[i].emOp});
      checkOutput($sformatf("v%0d_illm", i), {63'd0, illm}, {63'd0, vecs[i].emOp == 3'd7});
    end
    applyStimulus(1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("stream_drained", {63'd0, vld32}, 64'd0);

    // Backpressure: A to main, B to skid, C refused until space frees.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 3'd0, 32'hA);
    @(negedge clk);
    checkOutput("bp_a_valid", {63'd0, vld32}, 64'd1);
    checkOutput("bp_a_imm", {32'd0, imm32}, 64'd1);
    checkOutput("bp_a_ready", {63'd0, rdy32}, 64'd1);
    applyStimulus(1'b1, 32'h00200093, 3'd0, 32'hB);
    @(negedge clk);
    checkOutput("bp_b_skid_ready", {63'd0, rdy32}, 64'd0);
    checkOutput("bp_a_held_imm", {32'd0, imm32}, 64'd1);
    applyStimulus(1'b1, 32'h00300093, 3'd0, 32'hC);
    @(negedge clk);
    checkOutput("bp_c_refused_ready", {63'd0, rdy32}, 64'd0);
    checkOutput("bp_a_still_tag", {32'd0, tag32}, 64'hA);
    checkOutput("bp_a_still_imm", {32'd0, imm32}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_b_valid", {63'd0, vld32}, 64'd1);
    checkOutput("bp_b_tag", {32'd0, tag32}, 64'hB);
    checkOutput("bp_b_imm", {32'd0, imm32}, 64'd2);
    checkOutput("bp_ready_back", {63'd0, rdy32}, 64'd1);
    @(negedge clk);
    checkOutput("bp_c_valid", {63'd0, vld32}, 64'd1);
    checkOutput("bp_c_tag", {32'd0, tag32}, 64'hC);
    checkOutput("bp_c_imm", {32'd0, imm32}, 64'd3);
    applyStimulus(1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("bp_empty", {63'd0, vld32}, 64'd0);

    // Flush with main and skid full and a new input offered.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00400093, 3'd0, 32'hD);
    @(negedge clk);
    applyStimulus(1'b1, 32'h00500093, 3'd0, 32'hE);
    @(negedge clk);
    checkOutput("fl_full_ready", {63'd0, rdy32}, 64'd0);
    applyStimulus(1'b1, 32'h00600093, 3'd0, 32'hF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'd0, 32'h0);
    checkOutput("fl_valid", {63'd0, vld32}, 64'd0);
    checkOutput("fl_valid64", {63'd0, vld64}, 64'd0);
    checkOutput("fl_ready", {63'd0, rdy32}, 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("fl_quiet%0d", k), {63'd0, vld32}, 64'd0);
    end

    // Flush discards an input that would otherwise have been accepted.
    applyStimulus(1'b1, 32'h00700093, 3'd0, 32'h77);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'd0, 32'h0);
    checkOutput("fl_in_dropped", {63'd0, vld32}, 64'd0);
    @(negedge clk);
    checkOutput("fl_in_dropped2", {63'd0, vld32}, 64'd0);

    // Reset applied while stalled with both entries held.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00800093, 3'd0, 32'h88);
    @(negedge clk);
    applyStimulus(1'b1, 32'h00900093, 3'd0, 32'h99);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 3'd0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("mrst_ready_low", {63'd0, rdy32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mrst_valid", {63'd0, vld32}, 64'd0);
    checkOutput("mrst_imm", {32'd0, imm32}, 64'd0);
    checkOutput("mrst_tag", {32'd0, tag32}, 64'd0);
    checkOutput("mrst_ready", {63'd0, rdy32}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mrst_quiet", {63'd0, vld32}, 64'd0);

    // Normal traffic resumes after the reset.
    applyStimulus(1'b1, 32'h00A00093, 3'd0, 32'hAA);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 3'd0, 32'h0);
    checkOutput("post_valid", {63'd0, vld32}, 64'd1);
    checkOutput("post_imm", {32'd0, imm32}, 64'd10);
    checkOutput("post_tag", {32'd0, tag32}, 64'hAA);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the pipelined core; successor to the single-cycle combinational sign-extender.
- Sits between the IF/ID instruction register and the ID/EX stage.
- Accepts one 32-bit instruction per cycle and emits an XLEN-wide immediate, the format code and a tag, with a 1-cycle latency.
- Holds up to two entries in a skid buffer so that downstream backpressure never drops data. Supports flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried alongside each instruction (normally the PC).
- AUTO_DECODE, 1: 1 = derive the format from the opcode/funct3; 0 = use in_op directly.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered entries and any input offered in the same cycle
- in_valid  input  1  upstream entry valid
- in_ready  output  1  block can accept an entry this cycle
- in_inst  input  32  raw instruction word
- in_op  input  3  format code; used only when AUTO_DECODE=0
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts the entry
- out_imm  output  XLEN  extended immediate
- out_op  output  3  resolved format code
- out_tag  output  TAG_W  tag of the entry
- out_illegal  output  1  opcode has no immediate format or is unsupported

Behaviour:
- Format codes: I=0, S=1, B=2, U=3, J=4, Z=5, SH=6; code 7 is reserved.
- Extraction, all results sign-extended from inst[31] to XLEN unless stated:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'h000}, then sign-extended from bit 31.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Z = zero-extended inst[19:15] (CSR zimm).
  - SH = zero-extended inst[25:20] when XLEN=64, inst[24:20] when XLEN=32.
- Auto decode, keyed on opcode inst[6:0]:
  - 0000011 and 1100111 → I.
  - 0010011 → SH if funct3 is 001 or 101, otherwise I.
  - 0011011 → valid only when XLEN=64: SH (5-bit) for funct3 001/101, otherwise I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111 and 0010111 → U.
  - 1101111 → J.
  - 1110011 → Z if funct3[2]=1, otherwise I.
  - Anything else, or inst[1:0]≠11 → out_illegal=1, out_imm=0, out_op=7.
- When AUTO_DECODE=0, an in_op value of 7 sets out_illegal=1 and out_imm=0.
- Handshake: a transfer occurs when valid and ready are both high on a rising clk edge. out_* are held stable while out_valid=1 and out_ready=0.
- Storage consists of a main register (drives out_*) and a skid register.
  - in_ready = !skid_valid, registered; forced to 0 while rst=1.
  - Accepted entry while main is empty, or while main is being drained this cycle without a skid entry → goes to main. Visible on out_* the next cycle (1-cycle latency).
  - Accepted entry while main is full and stalled → goes to skid. in_ready drops the next cycle.
  - Main drained while skid is valid → skid moves to main. A simultaneous accept is impossible because in_ready=0.
  - Full throughput: one entry per cycle when out_ready is held at 1.
- Ordering: strictly FIFO; no reordering between main and skid.
- Flush has priority over everything. On the next edge both valid bits clear, and an input accepted in the flush cycle is discarded. in_ready=1 in the following cycle.
- Reset: out_valid=0, out_imm=0, out_op=0, out_tag=0, out_illegal=0, skid cleared. in_ready=1 from the first cycle after rst deasserts. A reset applied mid-stall drops all entries.

Decomposition:
- Shared package imm_pkg holds:
  - Format-code localparams (IMM_I … IMM_SH, IMM_RSVD).
  - RISC-V opcode constants.
  - A struct or typedef for the {imm, op, tag, illegal} payload.
- One combinational sub-module, imm_extract (inst, op, XLEN → imm, illegal), instantiated once. The top level holds the decode and the two-entry skid control.

Test Plan:
- Reset, then stream with out_ready=1:
  - addi x1,x0,-1 (0xFFF00093), XLEN=32 → next cycle out_imm=0xFFFFFFFF, op=0.
  - lui 0x12345 (0x123450B7) → out_imm=0x12345000, op=3.
- Branch/jump:
  - beq with offset -4 (0xFE000EE3) → out_imm=0xFFFFFFFC, op=2.
  - jal +2048 (0x001000EF) → out_imm=0x00000800, op=4.
- Backpressure: hold out_ready=0 and offer 3 instructions A, B, C back-to-back.
  - A is held in main, B goes to skid, in_ready=0, C is not accepted.
  - Release out_ready → A, B, C emerge in order, with no gaps once C is accepted.
- XLEN=64:
  - slli x1,x1,63 (0x03F09093) → out_imm=0x3F, op=6.
  - lui 0x80000 → out_imm=0xFFFFFFFF80000000.
- csrrwi with zimm=31 (0x000FD073) → out_imm=0x1F, op=5. Opcode 0x0000007F → out_illegal=1, out_imm=0, op=7.
- Flush with main and skid both full and an input offered in the same cycle → out_valid=0 the next cycle, in_ready=1, and no flushed entry ever appears. rst asserted mid-stall gives the same result.
